// File: rtl/mmc_cmd_engine_pkg.sv
// rtl/mmc_cmd_engine_pkg.sv - shared constants, state encoding and CRC7 step for the MMC command engine
package mmc_cmd_engine_pkg;

  // Command/response frame length in bits, and how many leading bits the CRC covers
  localparam int FRAME_LEN = 48;
  localparam int CRC_BITS  = 40;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // R2/R3-style responses report this index and carry no real CRC
  localparam logic [5:0] R3_IDX = 6'h3F;

  // rsp_err bit positions
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_NCR  = 3'd2,
    ST_RX   = 3'd3,
    ST_NRC  = 3'd4
  } state_t;

  // One serial CRC7 step, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// rtl/mmc_crc7.sv - serial CRC7 with clear and enable, shared by transmit and receive
module mmc_crc7
  import mmc_cmd_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  // Clear wins over a data step
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mmc_cmd_engine.sv
// rtl/mmc_cmd_engine.sv - MMC CMD-line serialiser, response capture and check
module mmc_cmd_engine
  import mmc_cmd_engine_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_BITS     = 8
) (
  input  logic        cclk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_idx,
  input  logic [31:0] req_arg,
  input  logic        req_resp,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in,
  output logic        rsp_valid,
  output logic [5:0]  rsp_idx,
  output logic [31:0] rsp_arg,
  output logic [1:0]  rsp_err
);

  localparam int CNT_W = 16;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         idx_q, idx_d;
  logic [31:0]        arg_q, arg_d;
  logic               resp_q, resp_d;
  logic               cmd_out_q, cmd_out_d;
  logic               cmd_oe_q, cmd_oe_d;
  logic [44:0]        rx_sr_q, rx_sr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [5:0]         rsp_idx_q, rsp_idx_d;
  logic [31:0]        rsp_arg_q, rsp_arg_d;
  logic [1:0]         rsp_err_q, rsp_err_d;

  logic               crc_clr, crc_en, crc_din;
  logic [6:0]         crc;
  logic [47:0]        tx_frame;
  logic               tx_bit;
  logic [45:0]        rx_word;
  logic               rx_crc_bad;

  mmc_crc7 u_crc7 (
    .clk (cclk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  // CRC field is only read from bit 40 on, by which time the CRC has frozen
  assign tx_frame = {1'b0, 1'b1, idx_q, arg_q, crc, 1'b1};
  assign tx_bit   = tx_frame[6'd47 - cnt_q[5:0]];

  // Response bits 2..47: idx, arg, crc, end (transmission bit has shifted out)
  assign rx_word    = {rx_sr_q, cmd_in};
  assign rx_crc_bad = (rx_word[45:40] != R3_IDX) && (rx_word[7:1] != crc);

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    resp_d      = resp_q;
    cmd_out_d   = cmd_out_q;
    cmd_oe_d    = cmd_oe_q;
    rx_sr_d     = rx_sr_q;
    rsp_valid_d = 1'b0;
    rsp_idx_d   = rsp_idx_q;
    rsp_arg_d   = rsp_arg_q;
    rsp_err_d   = rsp_err_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_din     = tx_bit;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d   = req_idx;
          arg_d   = req_arg;
          resp_d  = req_resp;
          cnt_d   = '0;
          crc_clr = 1'b1;
          state_d = ST_TX;
        end
      end

      ST_TX: begin
        if (bit_en) begin
          if (cnt_q < CNT_W'(FRAME_LEN)) begin
            cmd_out_d = tx_bit;
            cmd_oe_d  = 1'b1;
            crc_en    = (cnt_q < CNT_W'(CRC_BITS));
            cnt_d     = cnt_q + CNT_W'(1);
          end else begin
            cmd_out_d = 1'b1;
            cmd_oe_d  = 1'b0;
            cnt_d     = '0;
            if (resp_q) begin
              state_d = ST_NCR;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = '0;
              state_d     = ST_NRC;
            end
          end
        end
      end

      ST_NCR: begin
        if (bit_en) begin
          if (!cmd_in) begin
            // CRC of a lone 0 start bit from a zero seed is zero, so clearing covers it
            crc_clr = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = ST_RX;
          end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
            rsp_err_d              = '0;
            rsp_err_d[ERR_TIMEOUT] = 1'b1;
            rsp_arg_d              = '0;
            rsp_valid_d            = 1'b1;
            cnt_d                  = '0;
            state_d                = ST_NRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RX: begin
        if (bit_en) begin
          crc_en  = (cnt_q < CNT_W'(CRC_BITS));
          crc_din = cmd_in;
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            rsp_idx_d          = rx_word[45:40];
            rsp_arg_d          = rx_word[39:8];
            rsp_err_d          = '0;
            rsp_err_d[ERR_CRC] = rx_crc_bad | ~rx_word[0];
            rsp_valid_d        = 1'b1;
            cnt_d              = '0;
            state_d            = ST_NRC;
          end else begin
            rx_sr_d = {rx_sr_q[43:0], cmd_in};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_NRC: begin
        if (bit_en) begin
          if (cnt_q == CNT_W'(NRC_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        cnt_d     = '0;
        cmd_out_d = 1'b1;
        cmd_oe_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      resp_q      <= 1'b0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      rx_sr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_arg_q   <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      cmd_out_q   <= cmd_out_d;
      cmd_oe_q    <= cmd_oe_d;
      rx_sr_q     <= rx_sr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_arg_q   <= rsp_arg_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign cmd_out   = cmd_out_q;
  assign cmd_oe    = cmd_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_arg   = rsp_arg_q;
  assign rsp_err   = rsp_err_q;

endmodule
